road_scroller: RTL and testbench
================================

Name: road_scroller

Overview:
- Consumes the 8-bit lane patterns produced by the lane generator.
- Scrolls them down an 8x8 playfield, one new top row per game tick.
- Checks the frog (always in the bottom row) against obstacles, keeps a score, and drives the row-scanned LED matrix.
- Sits between the lane generator and the LED matrix driver pins.

Parameters:
SCAN_DIV, 16, clocks spent on each matrix row before the scan advances (2..65535).

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
tick  input  1  single-cycle game-advance strobe
line_in  input  8  lane pattern from generator; bit=0 is an obstacle, bit=1 is free
line_take  output  1  asserted in the cycle line_in is consumed; generator advances on it
frog_col  input  3  frog column in the bottom row (row 0)
pause  input  1  level; freezes scrolling
restart  input  1  single-cycle strobe; clears the game
crash  output  1  high while in CRASH
score  output  8  rows survived, saturating
row_sel  output  8  one-hot active-high matrix row select
col_data  output  8  active-high column drive for the selected row

Behaviour:
- Clock and reset: one clock, clock; reset is asynchronous and active-high.
- Reset values (asynchronous):
  - state=RUN
  - frame rows 0..7 = 8'hFF
  - score=0, crash=0, line_take=0
  - scan counter=0, row index=0
  - row_sel=0, col_data=0
- Frame: 8 registers; row 7 is the top, row 0 the bottom (frog row).
- States: RUN, PAUSE, CRASH.
- Hit condition: frame[0][frog_col]==0. Evaluated every cycle on the registered row 0.
- Transition priority, highest first:
  1. restart
  2. hit
  3. pause
  4. tick
- RUN:
  - restart -> frame all 8'hFF, score 0, stay in RUN.
  - Else hit -> CRASH next cycle. Tick in the same cycle is ignored: no shift, line_take=0.
  - Else pause=1 -> PAUSE. Tick ignored.
  - Else tick=1 -> shift in the same clock edge:
    - row[k] <= row[k+1] for k=0..6
    - row[7] <= line_in
    - score <= min(score+1, 255)
    - line_take=1 combinationally during that cycle
- PAUSE:
  - Frame and score frozen; tick ignored; line_take=0.
  - restart -> clear, go to RUN.
  - Else hit -> CRASH (frog moved onto an obstacle).
  - Else pause=0 -> RUN next cycle.
- CRASH:
  - crash=1; frame and score frozen; tick and pause ignored; line_take=0.
  - Only restart exits: clears frame and score, RUN next cycle, crash=0 that cycle onward.
- line_take is never asserted outside RUN and is never asserted for more than one cycle per tick.
- Score saturates at 255; further shifts leave it at 255.
- Scan, free-running in all states:
  - Scan counter counts 0..SCAN_DIV-1.
  - On wrap, row index increments 0..7 and wraps 7->0.
- Scan outputs, registered (updated every clock from the current row index r and frame):
  - row_sel = 1<<r
  - col_data = ~frame[r], with bit frog_col additionally set when r==0
  - Latency: one clock after the index/frame change.
- frog_col changes take effect for the hit check the same cycle they are sampled; no debounce.
- Reset asserted mid-operation (including during a shift or CRASH): immediate return to reset values; no line_take.

Test Plan:
- Reset then 8 ticks, line_in=8'hCF each, frog_col=0 (bit0=1, free) -> 8 line_take pulses, all rows 8'hCF, score=8, crash=0.
- From an all-8'hFF frame, 8 ticks with line_in=8'hF3, then set frog_col=2 -> crash=1 next cycle. A further tick gives no line_take and score stays 8.
- tick and pause=1 asserted together in RUN -> no shift, line_take=0, state PAUSE. Release pause, tick -> shift occurs, score increments by 1.
- In CRASH, pulse restart -> crash=0, frame all 8'hFF, score=0. Next tick shifts line_in into row 7.
- 260 ticks on line_in=8'hFF -> score saturates at 255.
- SCAN_DIV=4, frame row 0=8'hE7, frog_col=1 -> row_sel sequence 01,02,04,...,80,01 advancing every 4 clocks. col_data=8'h1A when row_sel=01. Reset mid-scan -> row_sel=0, col_data=0 immediately.

Source files
------------

// File: rtl/road_scroller.sv
// Scrolls generator lane patterns down an 8x8 playfield, checks the frog in the
// bottom row for collisions, keeps a saturating score and scans the LED matrix.
module road_scroller #(
   parameter int SCAN_DIV = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick,
   input  logic [7:0] line_in,
   output logic       line_take,
   input  logic [2:0] frog_col,
   input  logic       pause,
   input  logic       restart,
   output logic       crash,
   output logic [7:0] score,
   output logic [7:0] row_sel,
   output logic [7:0] col_data
);

   // state | meaning
   // RUN   | scrolling on each tick
   // PAUSE | frame and score frozen until pause drops
   // CRASH | frog hit an obstacle; only restart exits
   typedef enum logic [1:0] {RUN, PAUSE, CRASH} state_t;

   localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

   state_t      state, state_nxt;
   logic [7:0]  frame [8];
   logic        hit, shift, clear;
   logic [15:0] scan_cnt;
   logic [2:0]  row_idx;

   always_comb begin
      state_nxt = state;
      shift     = 1'b0;
      clear     = 1'b0;
      hit       = ~frame[0][frog_col];
      case (state)
         RUN: begin
            if (restart)    clear = 1'b1;
            else if (hit)   state_nxt = CRASH;
            else if (pause) state_nxt = PAUSE;
            else if (tick)  shift = 1'b1;
         end
         PAUSE: begin
            if (restart) begin
               clear     = 1'b1;
               state_nxt = RUN;
            end
            else if (hit)    state_nxt = CRASH;
            else if (!pause) state_nxt = RUN;
         end
         CRASH: begin
            if (restart) begin
               clear     = 1'b1;
               state_nxt = RUN;
            end
         end
         default: state_nxt = RUN;
      endcase
      line_take = shift & ~reset;
   end

   assign crash = (state == CRASH);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= RUN;
         score <= 8'd0;
         for (int k = 0; k < 8; k++) frame[k] <= 8'hFF;
      end
      else begin
         state <= state_nxt;
         if (clear) begin
            score <= 8'd0;
            for (int k = 0; k < 8; k++) frame[k] <= 8'hFF;
         end
         else if (shift) begin
            for (int k = 0; k < 7; k++) frame[k] <= frame[k+1];
            frame[7] <= line_in;
            if (score != 8'hFF) score <= score + 8'd1;
         end
      end
   end

   // Matrix scan runs regardless of game state so the display never blanks.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         scan_cnt <= 16'd0;
         row_idx  <= 3'd0;
         row_sel  <= 8'h00;
         col_data <= 8'h00;
      end
      else begin
         if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= 16'd0;
            row_idx  <= row_idx + 3'd1;
         end
         else begin
            scan_cnt <= scan_cnt + 16'd1;
         end
         row_sel  <= 8'h01 << row_idx;
         col_data <= ~frame[row_idx] | ((row_idx == 3'd0) ? (8'h01 << frog_col) : 8'h00);
      end
   end

endmodule

// File: tb/tb_road_scroller.sv
// Scoreboard bench for road_scroller: line_take and scanned column data are
// predicted by a small frame/score model and compared as the DUT produces them.
module tb_road_scroller;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       tick = 1'b0;
   logic [7:0] line_in = 8'h00;
   logic       line_take;
   logic [2:0] frog_col = 3'd0;
   logic       pause = 1'b0;
   logic       restart = 1'b0;
   logic       crash;
   logic [7:0] score;
   logic [7:0] row_sel;
   logic [7:0] col_data;

   int checks = 0;
   int failures = 0;

   logic [7:0] mf [8];
   int         ms;
   logic       take_q [$];
   logic [7:0] col_q [$];

   road_scroller #(.SCAN_DIV(4)) dut (
      .clock(clock), .reset(reset), .tick(tick), .line_in(line_in),
      .line_take(line_take), .frog_col(frog_col), .pause(pause),
      .restart(restart), .crash(crash), .score(score),
      .row_sel(row_sel), .col_data(col_data)
   );

   always #5 clock = ~clock;

   task automatic model_clear();
      for (int k = 0; k < 8; k++) mf[k] = 8'hFF;
      ms = 0;
   endtask

   task automatic do_tick(input logic [7:0] li, input logic exp_take);
      logic e;
      @(negedge clock);
      line_in = li;
      tick = 1'b1;
      take_q.push_back(exp_take);
      #1;
      e = take_q.pop_front();
      checks++;
      if (line_take !== e) begin
         failures++;
         $display("FAIL line_take: got %b expected %b", line_take, e);
      end
      if (exp_take) begin
         for (int k = 0; k < 7; k++) mf[k] = mf[k+1];
         mf[7] = li;
         if (ms < 255) ms++;
      end
      @(negedge clock);
      tick = 1'b0;
   endtask

   task automatic do_restart();
      @(negedge clock);
      restart = 1'b1;
      @(negedge clock);
      restart = 1'b0;
      model_clear();
   endtask

   task automatic dump_frame(input string nm);
      logic [7:0] ec;
      int n;
      for (int k = 0; k < 8; k++)
         col_q.push_back(~mf[k] | ((k == 0) ? 8'(8'h01 << frog_col) : 8'h00));
      for (int k = 0; k < 8; k++) begin
         n = 0;
         do begin
            @(negedge clock);
            n++;
         end while (row_sel !== 8'(1 << k) && n < 64);
         ec = col_q.pop_front();
         checks++;
         if (row_sel !== 8'(1 << k)) begin
            failures++;
            $display("FAIL %s row%0d timeout: row_sel %h expected %h", nm, k, row_sel, 8'(1 << k));
         end
         else if (col_data !== ec) begin
            failures++;
            $display("FAIL %s row%0d col_data: got %h expected %h", nm, k, col_data, ec);
         end
      end
   endtask

   task automatic check_val(input string nm, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic test_reset();
      model_clear();
      repeat (3) @(negedge clock);
      check_val("reset row_sel", row_sel, 8'h00);
      check_val("reset col_data", col_data, 8'h00);
      check_val("reset score", score, 8'h00);
      check_val("reset crash", {7'd0, crash}, 8'h00);
      check_val("reset line_take", {7'd0, line_take}, 8'h00);
      reset = 1'b0;
      dump_frame("reset frame");
   endtask

   task automatic test_fill();
      frog_col = 3'd0;
      for (int i = 0; i < 8; i++) do_tick(8'hCF, 1'b1);
      check_val("fill score", score, 8'd8);
      check_val("fill crash", {7'd0, crash}, 8'h00);
      dump_frame("fill frame");
   endtask

   task automatic test_crash();
      do_restart();
      frog_col = 3'd0;
      for (int i = 0; i < 8; i++) do_tick(8'hF3, 1'b1);
      check_val("pre-crash score", score, 8'd8);
      @(negedge clock);
      frog_col = 3'd2;
      @(negedge clock);
      check_val("crash flag", {7'd0, crash}, 8'h01);
      do_tick(8'h00, 1'b0);
      check_val("crash score frozen", score, 8'd8);
      @(negedge clock);
      pause = 1'b1;
      @(negedge clock);
      pause = 1'b0;
      check_val("crash held", {7'd0, crash}, 8'h01);
   endtask

   task automatic test_restart();
      do_restart();
      check_val("restart crash", {7'd0, crash}, 8'h00);
      check_val("restart score", score, 8'h00);
      dump_frame("restart frame");
      do_tick(8'h5A, 1'b1);
      check_val("restart tick score", score, 8'd1);
      dump_frame("restart shift frame");
   endtask

   task automatic test_pause();
      logic e;
      int s0;
      s0 = ms;
      @(negedge clock);
      pause = 1'b1;
      tick = 1'b1;
      line_in = 8'h77;
      take_q.push_back(1'b0);
      #1;
      e = take_q.pop_front();
      checks++;
      if (line_take !== e) begin
         failures++;
         $display("FAIL pause+tick line_take: got %b expected %b", line_take, e);
      end
      @(negedge clock);
      tick = 1'b0;
      check_val("pause score", score, 8'(s0));
      do_tick(8'h77, 1'b0);
      @(negedge clock);
      pause = 1'b0;
      do_tick(8'h3C, 1'b1);
      check_val("unpause score", score, 8'(s0 + 1));
      dump_frame("pause frame");
   endtask

   task automatic test_saturate();
      do_restart();
      frog_col = 3'd0;
      for (int i = 0; i < 260; i++) begin
         do_tick(8'hFF, 1'b1);
         if (i == 254) check_val("score at 255th tick", score, 8'(ms));
      end
      check_val("score saturated", score, 8'd255);
   endtask

   task automatic test_scan();
      int n;
      do_restart();
      frog_col = 3'd0;
      for (int i = 0; i < 8; i++) do_tick(8'hE7, 1'b1);
      frog_col = 3'd1;
      n = 0;
      do begin @(negedge clock); n++; end while (row_sel !== 8'h01 && n < 64);
      do begin @(negedge clock); n++; end while (row_sel !== 8'h02 && n < 128);
      checks++;
      if (row_sel !== 8'h02) begin
         failures++;
         $display("FAIL scan sync: got %h expected %h", row_sel, 8'h02);
      end
      for (int idx = 1; idx <= 8; idx++) begin
         for (int j = 0; j < 4; j++) begin
            if (!(idx == 1 && j == 0)) @(negedge clock);
            check_val("scan row_sel", row_sel, 8'(1 << (idx % 8)));
            if (idx == 8 && j == 0) check_val("scan col_data row0", col_data, 8'h1A);
         end
      end
      @(negedge clock);
      #2;
      tick = 1'b1;
      reset = 1'b1;
      #1;
      check_val("midscan reset row_sel", row_sel, 8'h00);
      check_val("midscan reset col_data", col_data, 8'h00);
      check_val("midscan reset score", score, 8'h00);
      check_val("midscan reset line_take", {7'd0, line_take}, 8'h00);
      @(negedge clock);
      tick = 1'b0;
      reset = 1'b0;
      model_clear();
      dump_frame("post-reset frame");
   endtask

   initial begin
      test_reset();
      test_fill();
      test_crash();
      test_restart();
      test_pause();
      test_saturate();
      test_scan();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
